restoring_division_top: RTL and testbench



---
 rtl/restoring_division_pkg.sv | 12 +
 rtl/restoring_division_datapath.sv | 58 +++++
 rtl/restoring_division_top.sv | 70 +++++++
 tb/tb_restoring_division_top.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/restoring_division_pkg.sv
// Shared constants and state encoding for the restoring divider.
package restoring_division_pkg;

  localparam int DIV_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/restoring_division_datapath.sv
// A/Q/M registers, shift-subtract-restore step and iteration counter.
module restoring_division_datapath #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] a,
  output logic             cnt_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  // A is kept at WIDTH bits between steps: after a restore it is always
  // below M, so its top bit is never set. The WIDTH+1-bit view exists only
  // inside the shift/subtract where the sign of the trial difference matters.
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] m_r;
  logic [CW-1:0]    cnt_r;

  logic [WIDTH:0]   a_sh;
  logic [WIDTH:0]   a_diff;
  logic             neg;

  always_comb begin
    a_sh   = {a_r, q_r[WIDTH-1]};
    a_diff = a_sh - {1'b0, m_r};
    neg    = a_diff[WIDTH];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_r   <= '0;
      q_r   <= '0;
      m_r   <= '0;
      cnt_r <= '0;
    end else if (load) begin
      a_r   <= '0;
      q_r   <= dividend;
      m_r   <= divisor;
      cnt_r <= CW'(WIDTH);
    end else if (step) begin
      a_r   <= neg ? a_sh[WIDTH-1:0] : a_diff[WIDTH-1:0];
      q_r   <= {q_r[WIDTH-2:0], ~neg};
      cnt_r <= cnt_r - CW'(1);
    end
  end

  assign q        = q_r;
  assign a        = a_r;
  assign cnt_zero = (cnt_r == '0);

endmodule

// File: rtl/restoring_division_top.sv
// Unsigned restoring divider: valid/ready operand intake, one quotient bit
// per clock, valid/ready result delivery with held outputs.
module restoring_division_top
  import restoring_division_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             src_valid,
  output logic             src_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             dest_valid,
  input  logic             dest_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  state_t           state;
  logic             load;
  logic             step;
  logic             cnt_zero;
  logic [WIDTH-1:0] dp_q;
  logic [WIDTH-1:0] dp_a;
  logic [WIDTH-1:0] quot_r;
  logic [WIDTH-1:0] rem_r;

  assign load = (state == IDLE) && src_valid;
  assign step = (state == CALC) && !cnt_zero;

  restoring_division_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .dividend (dividend),
    .divisor  (divisor),
    .q        (dp_q),
    .a        (dp_a),
    .cnt_zero (cnt_zero)
  );

  // Results are captured once on entry to DONE so they survive the next
  // operation's load and keep the last answer visible in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      quot_r <= '0;
      rem_r  <= '0;
    end else begin
      case (state)
        IDLE: if (src_valid) state <= CALC;
        CALC: if (cnt_zero) begin
          state  <= DONE;
          quot_r <= dp_q;
          rem_r  <= dp_a;
        end
        DONE: if (dest_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign src_ready  = (state == IDLE);
  assign dest_valid = (state == DONE);
  assign quotient   = quot_r;
  assign remainder  = rem_r;

endmodule

// File: tb/tb_restoring_division_top.sv
// Directed-vector and corner-sequence bench for the restoring divider.
module tb_restoring_division_top;

  logic        clk = 1'b0;
  logic        rst;
  logic        src_valid;
  logic        src_ready;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        dest_valid;
  logic        dest_ready;
  logic [15:0] quotient;
  logic [15:0] remainder;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [15:0] dd;
    logic [15:0] dv;
    logic [15:0] q;
    logic [15:0] r;
  } vec_t;

  vec_t vecs[9];

  restoring_division_top #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .dest_valid (dest_valid),
    .dest_ready (dest_ready),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Present operands for one cycle, then wait (bounded) for dest_valid.
  task automatic run_div(input logic [15:0] dd, input logic [15:0] dv,
                         output logic [15:0] q, output logic [15:0] r, output int lat);
    @(negedge clk);
    dividend  = dd;
    divisor   = dv;
    src_valid = 1'b1;
    @(posedge clk); #1;
    src_valid = 1'b0;
    dividend  = 16'hDEAD;
    divisor   = 16'h0003;
    lat = 0;
    while (!dest_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    q = quotient;
    r = remainder;
  endtask

  task automatic release_result(input logic [15:0] q_exp);
    @(negedge clk);
    dest_ready = 1'b1;
    @(posedge clk); #1;
    dest_ready = 1'b0;
    chk("dest_valid_drop", {31'd0, dest_valid}, 32'd0);
    chk("src_ready_back", {31'd0, src_ready}, 32'd1);
    chk("quot_retained", {16'd0, quotient}, {16'd0, q_exp});
  endtask

  initial begin
    logic [15:0] q, r, dd, dv, eq, er;
    int lat;

    vecs[0] = '{16'd65234, 16'd32770, 16'd1,     16'd32464};
    vecs[1] = '{16'd100,   16'd7,     16'd14,    16'd2};
    vecs[2] = '{16'd3,     16'd10,    16'd0,     16'd3};
    vecs[3] = '{16'hFFFF,  16'd1,     16'hFFFF,  16'd0};
    vecs[4] = '{16'd5,     16'd0,     16'hFFFF,  16'd5};
    vecs[5] = '{16'd0,     16'd5,     16'd0,     16'd0};
    vecs[6] = '{16'hFFFF,  16'hFFFF,  16'd1,     16'd0};
    vecs[7] = '{16'd1000,  16'd33,    16'd30,    16'd10};
    vecs[8] = '{16'd40000, 16'd200,   16'd200,   16'd0};

    rst = 1'b0; src_valid = 1'b0; dest_ready = 1'b0;
    dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_src_ready", {31'd0, src_ready}, 32'd1);
    chk("rst_dest_valid", {31'd0, dest_valid}, 32'd0);
    chk("rst_quotient", {16'd0, quotient}, 32'd0);
    chk("rst_remainder", {16'd0, remainder}, 32'd0);
    @(negedge clk); rst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_div(vecs[i].dd, vecs[i].dv, q, r, lat);
      chk($sformatf("vec%0d_latency", i), lat, 32'd17);
      chk($sformatf("vec%0d_quotient", i), {16'd0, q}, {16'd0, vecs[i].q});
      chk($sformatf("vec%0d_remainder", i), {16'd0, r}, {16'd0, vecs[i].r});
      release_result(vecs[i].q);
    end

    // Backpressure: result must hold while dest_ready stays low.
    run_div(16'd1000, 16'd33, q, r, lat);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp_dest_valid", {31'd0, dest_valid}, 32'd1);
      chk("bp_quotient", {16'd0, quotient}, 32'd30);
      chk("bp_remainder", {16'd0, remainder}, 32'd10);
    end
    release_result(16'd30);

    // Reset in the middle of an iteration aborts the operation.
    @(negedge clk);
    dividend = 16'd999; divisor = 16'd4; src_valid = 1'b1;
    @(posedge clk); #1;
    src_valid = 1'b0;
    chk("calc_src_ready_low", {31'd0, src_ready}, 32'd0);
    repeat (5) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("midrst_dest_valid", {31'd0, dest_valid}, 32'd0);
    chk("midrst_src_ready", {31'd0, src_ready}, 32'd1);
    chk("midrst_quotient", {16'd0, quotient}, 32'd0);
    chk("midrst_remainder", {16'd0, remainder}, 32'd0);
    @(negedge clk); rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("midrst_no_output", {31'd0, dest_valid}, 32'd0);

    run_div(16'd100, 16'd7, q, r, lat);
    chk("post_rst_latency", lat, 32'd17);
    chk("post_rst_quotient", {16'd0, q}, 32'd14);
    chk("post_rst_remainder", {16'd0, r}, 32'd2);
    release_result(16'd14);

    for (int i = 0; i < 100; i++) begin
      dd = 16'($urandom);
      dv = (i % 10 == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
      if (i % 3 == 0) dv = 16'($urandom_range(1, 300));
      eq = (dv == 0) ? 16'hFFFF : dd / dv;
      er = (dv == 0) ? dd : dd % dv;
      run_div(dd, dv, q, r, lat);
      chk($sformatf("rnd%0d_quotient %0d/%0d", i, dd, dv), {16'd0, q}, {16'd0, eq});
      chk($sformatf("rnd%0d_remainder %0d/%0d", i, dd, dv), {16'd0, r}, {16'd0, er});
      @(negedge clk); dest_ready = 1'b1;
      @(posedge clk); #1; dest_ready = 1'b0;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
